data_memory_bytelane: RTL and testbench

//   Parametrised word-organised data memory for the single-cycle CPU's load/store path.

---
 rtl/data_memory_bytelane_if.sv | 24 ++
 rtl/data_memory_bytelane.sv | 137 +++++++++++++
 tb/tb_data_memory_bytelane.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_bytelane_if.sv
// Request/response channel between the MEM stage and the byte-lane data memory.
interface data_memory_bytelane_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_bytelane.sv
// Word-organised data memory with byte/half/word lane access, load extension,
// error flagging and a post-reset clear sweep. Fixed 1-cycle response.
module data_memory_bytelane #(
  parameter int unsigned DEPTH          = 128,
  parameter int unsigned ADDR_W         = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  data_memory_bytelane_if.slave  bus,
  output logic                   busy
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_clr_ptr, w_clr_ptr_nxt;
  logic             w_clr_we;
  logic [31:0]      r_mem [DEPTH];

  logic             w_accept, w_store, w_err;
  logic             w_misaligned, w_bad_size, w_oor;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]       w_be;
  logic [31:0]      w_lane_data, w_word, w_load_ext;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;

  // State register and sweep pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  // Next-state: sweep every word once, then sit in IDLE accepting requests
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    w_clr_we      = 1'b0;
    bus.req_ready = 1'b0;
    busy          = 1'b0;
    unique case (r_state)
      S_CLEAR: begin
        if (CLEAR_ON_RESET) begin
          busy          = 1'b1;
          w_clr_we      = 1'b1;
          w_clr_ptr_nxt = r_clr_ptr + 1'b1;
          if (r_clr_ptr == IDX_W'(DEPTH - 1)) w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: bus.req_ready = 1'b1;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Request decode: index, error classification, lane enables and store data
  always_comb begin
    w_idx        = bus.req_addr[IDX_W+1:2];
    w_oor        = (bus.req_addr >> (IDX_W + 2)) != '0;
    w_misaligned = 1'b0;
    w_bad_size   = 1'b0;
    unique case (bus.req_size)
      3'd0, 3'd4: w_misaligned = 1'b0;
      3'd1, 3'd5: w_misaligned = bus.req_addr[0];
      3'd2:       w_misaligned = bus.req_addr[1:0] != 2'b00;
      default:    w_bad_size   = 1'b1;
    endcase
    if (bus.req_we && bus.req_size[2]) w_bad_size = 1'b1;
    w_err    = w_misaligned | w_bad_size | w_oor;
    w_accept = bus.req_valid & bus.req_ready;
    w_store  = w_accept & bus.req_we & ~w_err;

    unique case (bus.req_size[1:0])
      2'd0: begin
        w_be        = 4'b0001 << bus.req_addr[1:0];
        w_lane_data = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        w_be        = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        w_lane_data = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        w_be        = 4'b1111;
        w_lane_data = bus.req_wdata;
      end
    endcase
  end

  // Load path: select lanes from the addressed word and extend
  always_comb begin
    w_word = r_mem[w_idx];
    w_byte = w_word[{bus.req_addr[1:0], 3'b000} +: 8];
    w_half = bus.req_addr[1] ? w_word[31:16] : w_word[15:0];
    unique case (bus.req_size)
      3'd0:    w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'd4:    w_load_ext = {24'd0, w_byte};
      3'd1:    w_load_ext = {{16{w_half[15]}}, w_half};
      3'd5:    w_load_ext = {16'd0, w_half};
      3'd2:    w_load_ext = w_word;
      default: w_load_ext = '0;
    endcase
  end

  // Array write port: sweep clears take the port in CLEAR, lane-merged stores in IDLE
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_store) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_lane_data[8*i +: 8];
      end
    end
  end

  // Response register: pulse valid one cycle after accept, hold data/err otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= w_accept;
      if (w_accept) begin
        bus.rsp_err   <= w_err;
        bus.rsp_rdata <= (w_err || bus.req_we) ? '0 : w_load_ext;
      end
    end
  end
endmodule

// File: tb/tb_data_memory_bytelane.sv
// Bench for data_memory_bytelane: byte-addressed reference model checked every
// cycle, plus directed transactions with hand-computed expected values.
module tb_data_memory_bytelane;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy;

  data_memory_bytelane_if #(.ADDR_W(32)) bus ();

  data_memory_bytelane #(
    .DEPTH(DEPTH), .ADDR_W(32), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: flat byte array, cycles counted since reset release
  logic [7:0]  mm [DEPTH*4];
  int unsigned cyc;
  logic        m_valid, m_err;
  logic [31:0] m_rdata;

  task automatic model_access(input logic we, input logic [2:0] sz,
                              input logic [31:0] a, input logic [31:0] wd);
    int unsigned nb;
    logic bad, mis, oor;
    logic [31:0] v;
    nb  = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
    bad = (sz == 3'd3) || (sz >= 3'd6) || (we && sz >= 3'd4);
    mis = (a % nb) != 0;
    oor = a >= DEPTH * 4;
    if (bad || mis || oor) begin
      m_err = 1'b1; m_rdata = 32'd0;
    end else if (we) begin
      for (int unsigned i = 0; i < nb; i++) mm[a+i] = wd[8*i +: 8];
      m_err = 1'b0; m_rdata = 32'd0;
    end else begin
      v = 32'd0;
      for (int unsigned i = 0; i < nb; i++) v = v | (32'(mm[a+i]) << (8*i));
      if (sz == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (sz == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      m_err = 1'b0; m_rdata = v;
    end
  endtask

  initial begin
    cyc = 0; m_valid = 1'b0; m_err = 1'b0; m_rdata = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cyc = 0; m_valid = 1'b0; m_err = 1'b0; m_rdata = '0;
        for (int unsigned i = 0; i < DEPTH*4; i++) mm[i] = 8'h00;
      end else begin
        m_valid = 1'b0;
        if (cyc >= DEPTH && bus.req_valid) begin
          model_access(bus.req_we, bus.req_size, bus.req_addr, bus.req_wdata);
          m_valid = 1'b1;
        end
        cyc++;
      end
    end
  end

  // Compare process: DUT vs model on every falling edge
  initial begin
    logic exp_ready;
    forever begin
      @(negedge clk);
      exp_ready = (rst_n === 1'b1) && (cyc >= DEPTH);
      check("req_ready", {31'd0, bus.req_ready}, {31'd0, exp_ready});
      check("busy",      {31'd0, busy},          {31'd0, ~exp_ready});
      check("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, m_valid});
      check("rsp_err",   {31'd0, bus.rsp_err},   {31'd0, m_err});
      check("rsp_rdata", bus.rsp_rdata, m_rdata);
    end
  end

  // Drive one request for one cycle; returns at the falling edge where its response is visible
  task automatic drive(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_addr = a; bus.req_wdata = wd;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic xact(input string name, input logic we, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
    drive(we, sz, a, wd);
    check({name, ".vld"}, {31'd0, bus.rsp_valid}, 32'd1);
    check({name, ".dat"}, bus.rsp_rdata, exp_d);
    check({name, ".err"}, {31'd0, bus.rsp_err}, {31'd0, exp_e});
  endtask

  task automatic count_busy(input string name);
    int unsigned n, pulses;
    n = 0; pulses = 0;
    while (busy === 1'b1 && n < 40) begin
      if (bus.rsp_valid) pulses++;
      n++;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    check({name, ".busy_cycles"}, n, 32'd16);
    check({name, ".no_rsp"}, pulses, 32'd0);
  endtask

  initial begin
    int unsigned pulses;
    logic [31:0] d;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 3'd2;
    bus.req_addr = '0; bus.req_wdata = '0;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("reset.busy",  {31'd0, busy}, 32'd1);
    rst_n = 1'b1;
    count_busy("sweep");

    for (int unsigned w = 0; w < DEPTH; w++) xact("clear_lw", 1'b0, 3'd2, w*4, 32'd0, 32'd0, 1'b0);
    idle();

    // Byte-lane merge; upper wdata bits must be ignored on SB/SH
    xact("sw8",  1'b1, 3'd2, 32'h8, 32'h1122_3344, 32'd0, 1'b0);
    xact("sb9",  1'b1, 3'd0, 32'h9, 32'hFFFF_FFAA, 32'd0, 1'b0);
    xact("shA",  1'b1, 3'd1, 32'hA, 32'h5555_BEEF, 32'd0, 1'b0);
    xact("lw8",  1'b0, 3'd2, 32'h8, 32'h0, 32'hBEEF_AA44, 1'b0);
    idle();

    // Load extension
    xact("sw4",   1'b1, 3'd2, 32'h4, 32'h80FF_7F01, 32'd0, 1'b0);
    xact("lb6",   1'b0, 3'd0, 32'h6, 32'h0, 32'hFFFF_FFFF, 1'b0);
    xact("lbu6",  1'b0, 3'd4, 32'h6, 32'h0, 32'h0000_00FF, 1'b0);
    xact("lh6",   1'b0, 3'd1, 32'h6, 32'h0, 32'hFFFF_80FF, 1'b0);
    xact("lhu4",  1'b0, 3'd5, 32'h4, 32'h0, 32'h0000_7F01, 1'b0);
    xact("lb5",   1'b0, 3'd0, 32'h5, 32'h0, 32'h0000_007F, 1'b0);
    idle();

    // Error cases leave memory untouched
    xact("sw0",    1'b1, 3'd2, 32'h0, 32'hCAFE_F00D, 32'd0, 1'b0);
    xact("sw_mis", 1'b1, 3'd2, 32'h2, 32'h1234_5678, 32'd0, 1'b1);
    xact("lh_mis", 1'b0, 3'd1, 32'h1, 32'h0, 32'd0, 1'b1);
    xact("lw_oor", 1'b0, 3'd2, DEPTH*4, 32'h0, 32'd0, 1'b1);
    xact("sw_oor", 1'b1, 3'd2, 32'h1000_0000, 32'h1234_5678, 32'd0, 1'b1);
    xact("size3",  1'b0, 3'd3, 32'h0, 32'h0, 32'd0, 1'b1);
    xact("sbu_st", 1'b1, 3'd4, 32'h0, 32'h0000_0011, 32'd0, 1'b1);
    xact("size7",  1'b1, 3'd7, 32'h0, 32'h0000_0022, 32'd0, 1'b1);
    xact("lw0",    1'b0, 3'd2, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0);
    idle();

    // Back-to-back alternating SW/LW to one address
    pulses = 0;
    d = 32'd0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        d = 32'h1000_0000 + i * 32'h0101_0101;
        drive(1'b1, 3'd2, 32'h10, d);
      end else begin
        drive(1'b0, 3'd2, 32'h10, 32'h0);
        check("b2b.lw", bus.rsp_rdata, d);
      end
      if (bus.rsp_valid) pulses++;
    end
    idle();
    check("b2b.pulses", pulses, 32'd8);

    // Reset mid-sweep with a request pending throughout
    @(negedge clk); #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 3'd2; bus.req_addr = 32'h0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_busy("midsweep");
    xact("post_lw", 1'b0, 3'd2, 32'h8, 32'h0, 32'd0, 1'b0);
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
